wd279x_crc_unit: RTL and testbench
==================================

Name: wd279x_crc_unit

Overview:
Parametrised CRC engine for the WD279x FDC data path. It extends the plain per-byte CRC accumulator with frame control, an MFM sync-mark preset, a generate mode and a check mode. Generate mode serialises the CRC bytes to the write path with a valid/ready handshake. Check mode produces a pass/fail flag from the zero residue. It sits between the track byte stream (read/write sequencer) and the status register logic.

Parameters:
CRC_WIDTH, 16, CRC register width; must be a multiple of 8 and at least 8 (elaboration assertion).
POLYNOM, 16'h1021, generator polynomial, MSB-first (non-reflected).
INIT, all ones, register value loaded on start with preset_mfm=0.
MFM_PRESET, 16'hCDB4, register value loaded on start with preset_mfm=1; equals INIT after A1 A1 A1.
NBYTES, CRC_WIDTH/8, number of CRC bytes emitted in generate mode (derived localparam).

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle frame start; loads the register and latches mode
preset_mfm  in  1  sampled with start: 1=MFM_PRESET, 0=INIT
mode  in  1  sampled with start: 0=generate, 1=check
data_in  in  8  frame byte
data_valid  in  1  data_in is accumulated this cycle (ACCUM state only)
frame_end  in  1  last byte of frame; may coincide with data_valid
crc  out  CRC_WIDTH  final register value, latched at frame_end
crc_ok  out  1  check-mode result (residue == 0); held until next start
done  out  1  one-cycle pulse when the frame completes
out_byte  out  8  generate-mode CRC byte, MSB byte first
out_valid  out  1  out_byte valid
out_ready  in  1  consumer accepts out_byte
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, register=INIT, crc=0, crc_ok=0, done=0, out_valid=0, out_byte=0, byte counter=0.
- States: IDLE, ACCUM, EMIT.
- start has the highest priority in every state. Next cycle: register=INIT or MFM_PRESET, mode latched, crc_ok=0, out_valid=0, state ACCUM. A start during EMIT aborts emission with no done pulse.
- ACCUM, data_valid=1: register <= step(register, data_in). Step: XOR the byte into the top 8 bits, then 8 shift/conditional-XOR-POLYNOM iterations, all in one cycle.
- ACCUM, frame_end=1: let V = step(register, data_in) when data_valid is also 1, else V = register. Next cycle: crc=V.
  - Generate mode: state EMIT, counter=0, out_valid=1, out_byte=V[CRC_WIDTH-1 -: 8].
  - Check mode: crc_ok=(V==0), done=1, state IDLE. Register reloads INIT.
- EMIT: out_byte = crc byte [NBYTES-1-counter] (MSB first).
  - On out_valid and out_ready: counter++.
  - After the last byte is accepted: out_valid=0, done=1, state IDLE.
  - out_byte and out_valid are stable while out_ready=0.
- data_valid and frame_end are ignored in IDLE and EMIT. frame_end with no prior data yields crc = preset value.
- Latency: crc, crc_ok and done appear 1 cycle after frame_end. The first out_byte appears 1 cycle after frame_end.
- done is never high for more than one cycle.

Decomposition:
- Package wd279x_pkg:
  - crc_state_t enum (IDLE, ACCUM, EMIT)
  - CRC16_CCITT_POLY=16'h1021, CRC16_INIT=16'hFFFF, CRC16_MFM_PRESET=16'hCDB4
  - parametrised crc_step function
- Optional sub-module wd279x_crc_step: combinational one-byte update, reused by the FSM and by any future parallel checker.

Test Plan:
- Generate: start(preset_mfm=0, mode=0), bytes "123456789" (31..39), frame_end on 0x39 -> crc=16'h29B1, out_byte 0x29 then 0xB1, done after 0xB1 accepted.
- Check: start(mode=1), "123456789" then 0x29, 0xB1 with frame_end on 0xB1 -> crc=0000, crc_ok=1, done 1 cycle. Repeat with 0x35 changed to 0x36 -> crc_ok=0.
- Preset equivalence:
  - start(preset_mfm=1), frame_end without data -> crc=CDB4.
  - start(preset_mfm=0), bytes A1 A1 A1, frame_end -> crc=CDB4.
- Backpressure: generate "123456789", hold out_ready=0 for 3 cycles -> out_byte stays 0x29 and out_valid=1. Pulse out_ready -> 0xB1. Then done.
- Abort/restart: start during ACCUM after 4 bytes, then full "123456789" -> crc=29B1. start during EMIT -> out_valid drops next cycle, no done.
- Reset mid-EMIT: reset_n low asynchronously -> out_valid=0, crc=0, busy=0 immediately. After release, a new frame computes correctly.

Source files
------------

// File: rtl/wd279x_pkg.sv
// WD279x CRC unit shared definitions.
// States, CCITT constants and the byte-wide CRC update.
package wd279x_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } crc_state_t;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT       = 16'hFFFF;
    localparam logic [15:0] CRC16_MFM_PRESET = 16'hCDB4;

    localparam int CRC_MAX = 64;

    // One byte, MSB first; width selects the live low bits of the
    // 64-bit carrier so one function serves every CRC_WIDTH.
    function automatic logic [CRC_MAX-1:0] crc_step(
        input logic [CRC_MAX-1:0] crc,
        input logic [7:0]         data,
        input logic [CRC_MAX-1:0] poly,
        input int                 width
    );
        logic [CRC_MAX-1:0] r;
        logic [CRC_MAX-1:0] mask;
        logic [CRC_MAX-1:0] top;
        logic               msb;
        mask = (CRC_MAX'(1) << width) - CRC_MAX'(1);
        top  = CRC_MAX'(1) << (width - 1);
        r    = crc ^ (CRC_MAX'(data) << (width - 8));
        for (int i = 0; i < 8; i++) begin
            msb = |(r & top);
            r   = (r << 1) & mask;
            if (msb) begin
                r = r ^ poly;
            end
        end
        return r & mask;
    endfunction

endpackage

// File: rtl/wd279x_crc_unit_if.sv
// Byte stream, frame control and CRC result bundle.
// master drives the frame, slave is the CRC unit.
interface wd279x_crc_unit_if #(
    parameter int CRC_WIDTH = 16
);
    logic                 start;
    logic                 preset_mfm;
    logic                 mode;
    logic [7:0]           data_in;
    logic                 data_valid;
    logic                 frame_end;
    logic [CRC_WIDTH-1:0] crc;
    logic                 crc_ok;
    logic                 done;
    logic [7:0]           out_byte;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;

    modport master (
        output start, preset_mfm, mode,
        output data_in, data_valid, frame_end,
        output out_ready,
        input  crc, crc_ok, done,
        input  out_byte, out_valid, busy
    );

    modport slave (
        input  start, preset_mfm, mode,
        input  data_in, data_valid, frame_end,
        input  out_ready,
        output crc, crc_ok, done,
        output out_byte, out_valid, busy
    );
endinterface

// File: rtl/wd279x_crc_step.sv
// Combinational one-byte CRC update.
// Shared by the frame FSM and any parallel checker.
module wd279x_crc_step
    import wd279x_pkg::*;
#(
    parameter int                   CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] POLYNOM   = CRC_WIDTH'(CRC16_CCITT_POLY)
) (
    input  logic [CRC_WIDTH-1:0] crc_i,
    input  logic [7:0]           data_i,
    output logic [CRC_WIDTH-1:0] crc_o
);
    logic [CRC_MAX-1:0] wide;
    logic               unused_par;

    assign wide = crc_step(CRC_MAX'(crc_i), data_i,
                           CRC_MAX'(POLYNOM), CRC_WIDTH);
    assign crc_o      = wide[CRC_WIDTH-1:0];
    assign unused_par = ^wide;
endmodule

// File: rtl/wd279x_crc_unit.sv
// WD279x frame CRC engine: generate (serialise CRC bytes)
// or check (zero residue) with MFM sync-mark preset.
module wd279x_crc_unit
    import wd279x_pkg::*;
#(
    parameter int                   CRC_WIDTH  = 16,
    parameter logic [CRC_WIDTH-1:0] POLYNOM    = CRC_WIDTH'(CRC16_CCITT_POLY),
    parameter logic [CRC_WIDTH-1:0] INIT       = '1,
    parameter logic [CRC_WIDTH-1:0] MFM_PRESET = CRC_WIDTH'(CRC16_MFM_PRESET)
) (
    input  logic               clk,
    input  logic               reset_n,
    wd279x_crc_unit_if.slave   bus
);
    localparam int NBYTES = CRC_WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    if (CRC_WIDTH % 8 != 0 || CRC_WIDTH < 8 || CRC_WIDTH > CRC_MAX) begin : g_bad_width
        $error("CRC_WIDTH must be a multiple of 8 in 8..64");
    end

    crc_state_t           state_q;
    logic [CRC_WIDTH-1:0] reg_q;
    logic                 mode_q;
    logic [CRC_WIDTH-1:0] crc_q;
    logic                 crc_ok_q;
    logic                 done_q;
    logic                 out_valid_q;
    logic [7:0]           out_byte_q;
    logic [CRC_WIDTH-1:0] emit_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [CRC_WIDTH-1:0] step_w;
    logic [CRC_WIDTH-1:0] v_w;
    logic [CRC_WIDTH-1:0] emit_nx;

    wd279x_crc_step #(
        .CRC_WIDTH (CRC_WIDTH),
        .POLYNOM   (POLYNOM)
    ) u_step (
        .crc_i  (reg_q),
        .data_i (bus.data_in),
        .crc_o  (step_w)
    );

    assign v_w     = bus.data_valid ? step_w : reg_q;
    assign emit_nx = emit_q << 8;

    // Frame FSM: start wins everywhere; done is a single-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            reg_q       <= INIT;
            mode_q      <= 1'b0;
            crc_q       <= '0;
            crc_ok_q    <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            emit_q      <= '0;
            cnt_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                reg_q       <= bus.preset_mfm ? MFM_PRESET : INIT;
                mode_q      <= bus.mode;
                crc_ok_q    <= 1'b0;
                out_valid_q <= 1'b0;
                cnt_q       <= '0;
                state_q     <= ACCUM;
            end else begin
                unique case (state_q)
                    ACCUM: begin
                        if (bus.data_valid) begin
                            reg_q <= step_w;
                        end
                        if (bus.frame_end) begin
                            crc_q <= v_w;
                            if (mode_q) begin
                                crc_ok_q <= (v_w == '0);
                                done_q   <= 1'b1;
                                reg_q    <= INIT;
                                state_q  <= IDLE;
                            end else begin
                                emit_q      <= v_w;
                                out_byte_q  <= v_w[CRC_WIDTH-1 -: 8];
                                out_valid_q <= 1'b1;
                                cnt_q       <= '0;
                                state_q     <= EMIT;
                            end
                        end
                    end
                    EMIT: begin
                        if (out_valid_q && bus.out_ready) begin
                            if (cnt_q == LAST) begin
                                out_valid_q <= 1'b0;
                                done_q      <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                cnt_q      <= cnt_q + 1'b1;
                                emit_q     <= emit_nx;
                                out_byte_q <= emit_nx[CRC_WIDTH-1 -: 8];
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.crc       = crc_q;
    assign bus.crc_ok    = crc_ok_q;
    assign bus.done      = done_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_wd279x_crc_unit.sv
// Bench for wd279x_crc_unit: directed frames plus
// random frames against a bit-serial CRC model.
module tb_wd279x_crc_unit;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    wd279x_crc_unit_if #(.CRC_WIDTH(W)) bus ();

    wd279x_crc_unit #(.CRC_WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] msg[$];
    logic [7:0] got[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial polynomial division over the message, MSB first.
    function automatic logic [15:0] ref_crc(input logic [15:0] init);
        int r;
        int fb;
        r = int'(init);
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = ((r >> 15) ^ (int'(msg[i]) >> b)) & 1;
                r  = (r << 1) & 32'hFFFF;
                if (fb != 0) r = r ^ 32'h1021;
            end
        end
        return 16'(r);
    endfunction

    task automatic load_digits();
        msg.delete();
        for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));
    endtask

    // Starts at a negedge; returns at the negedge where results show.
    task automatic run_frame(input bit pre, input bit md, input bit gaps);
        bus.start      = 1'b1;
        bus.preset_mfm = pre;
        bus.mode       = md;
        bus.data_valid = 1'b0;
        bus.frame_end  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        foreach (msg[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.data_valid = 1'b0;
                bus.frame_end  = 1'b0;
                bus.data_in    = 8'($urandom);
                @(negedge clk);
            end
            bus.data_valid = 1'b1;
            bus.data_in    = msg[i];
            bus.frame_end  = (i == msg.size() - 1);
            @(negedge clk);
        end
        if (msg.size() == 0) begin
            bus.frame_end = 1'b1;
            @(negedge clk);
        end
        bus.data_valid = 1'b0;
        bus.frame_end  = 1'b0;
    endtask

    task automatic collect(input bit rnd, output bit done_seen);
        bit         rdy;
        bit         held;
        logic [7:0] last_b;
        got.delete();
        done_seen = 1'b0;
        held      = 1'b0;
        last_b    = '0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            if (held) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_byte", bus.out_byte, last_b);
            end
            if (bus.done) begin
                done_seen = 1'b1;
                chk("done_valid_low", bus.out_valid, 0);
            end else begin
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.out_ready = rdy;
                held   = bus.out_valid && !rdy;
                last_b = bus.out_byte;
                if (bus.out_valid && rdy) got.push_back(bus.out_byte);
                @(negedge clk);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic check_gen(input logic [15:0] v, input bit rnd);
        bit ds;
        chk("gen_valid", bus.out_valid, 1);
        chk("gen_first", bus.out_byte, v[15:8]);
        collect(rnd, ds);
        chk("gen_done", ds, 1);
        chk("gen_nbytes", got.size(), 2);
        if (got.size() == 2) begin
            chk("gen_b0", got[0], v[15:8]);
            chk("gen_b1", got[1], v[7:0]);
        end
        chk("gen_idle", bus.busy, 0);
        @(negedge clk);
        chk("gen_done_pulse", bus.done, 0);
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] init;
        bit          pre;
        bit          md;
        bit          good;
        int          n;

        bus.start      = 1'b0;
        bus.preset_mfm = 1'b0;
        bus.mode       = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.frame_end  = 1'b0;
        bus.out_ready  = 1'b0;

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_crc", bus.crc, 0);
        chk("rst_ok", bus.crc_ok, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_byte", bus.out_byte, 0);

        load_digits();
        run_frame(0, 0, 0);
        chk("gen_crc", bus.crc, 16'h29B1);
        chk("gen_model", bus.crc, ref_crc(16'hFFFF));
        check_gen(16'h29B1, 0);

        load_digits();
        msg.push_back(8'h29);
        msg.push_back(8'hB1);
        run_frame(0, 1, 0);
        chk("chk_done", bus.done, 1);
        chk("chk_crc", bus.crc, 0);
        chk("chk_ok", bus.crc_ok, 1);
        chk("chk_busy", bus.busy, 0);
        @(negedge clk);
        chk("chk_done_pulse", bus.done, 0);
        chk("chk_ok_held", bus.crc_ok, 1);

        msg[4] = 8'h36;
        run_frame(0, 1, 0);
        chk("bad_done", bus.done, 1);
        chk("bad_ok", bus.crc_ok, 0);
        chk("bad_crc", bus.crc, ref_crc(16'hFFFF));

        msg.delete();
        run_frame(1, 1, 0);
        chk("mfm_crc", bus.crc, 16'hCDB4);
        msg = '{8'hA1, 8'hA1, 8'hA1};
        run_frame(0, 1, 0);
        chk("a1_crc", bus.crc, 16'hCDB4);

        load_digits();
        run_frame(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_byte", bus.out_byte, 8'h29);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_second", bus.out_byte, 8'hB1);
        chk("bp_no_done", bus.done, 0);
        @(negedge clk);
        chk("bp_still", bus.out_byte, 8'hB1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_done", bus.done, 1);
        chk("bp_vlow", bus.out_valid, 0);
        @(negedge clk);

        msg = '{8'h31, 8'h32, 8'h33, 8'h34};
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        foreach (msg[i]) begin
            bus.data_valid = 1'b1;
            bus.data_in    = msg[i];
            @(negedge clk);
        end
        bus.data_valid = 1'b0;
        load_digits();
        run_frame(0, 0, 0);
        chk("restart_crc", bus.crc, 16'h29B1);
        chk("emit_valid", bus.out_valid, 1);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_busy", bus.busy, 1);
        bus.frame_end = 1'b1;
        @(negedge clk);
        bus.frame_end = 1'b0;
        chk("abort_fe_done", bus.done, 1);
        chk("abort_fe_crc", bus.crc, 16'hFFFF);
        chk("abort_fe_ok", bus.crc_ok, 0);
        @(negedge clk);

        load_digits();
        run_frame(0, 0, 0);
        chk("pre_rst_valid", bus.out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_crc", bus.crc, 0);
        chk("arst_busy", bus.busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_frame(0, 0, 0);
        chk("post_rst_crc", bus.crc, 16'h29B1);
        check_gen(16'h29B1, 1);

        for (int t = 0; t < 40; t++) begin
            pre  = 1'($urandom_range(0, 1));
            md   = 1'($urandom_range(0, 1));
            good = 1'($urandom_range(0, 1));
            init = pre ? 16'hCDB4 : 16'hFFFF;
            n    = $urandom_range(0, 10);
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            if (md && good) begin
                v = ref_crc(init);
                msg.push_back(v[15:8]);
                msg.push_back(v[7:0]);
            end
            v = ref_crc(init);
            run_frame(pre, md, 1);
            chk("rnd_crc", bus.crc, v);
            if (md) begin
                chk("rnd_done", bus.done, 1);
                chk("rnd_ok", bus.crc_ok, (v == 16'h0));
                @(negedge clk);
            end else begin
                check_gen(v, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
